// File: rtl/alu_calc_ctrl.sv
// alu_calc_ctrl: push-button driven initiator that sequences the lab ALU and accumulates its result
module alu_calc_ctrl #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clr,
    input  logic [2:0]               op_sel,
    input  logic [OPERAND_WIDTH-1:0] operand_in,
    output logic [31:0]              alu_op1,
    output logic [31:0]              alu_op2,
    output logic [3:0]               alu_op,
    input  logic [31:0]              alu_result,
    input  logic                     alu_zero,
    output logic [31:0]              accumulator,
    output logic                     acc_zero,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               op_count
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [2:0]               sync_q, sync_d;
    logic [1:0]               state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [2:0]               op_q, op_d;
    logic [OPERAND_WIDTH-1:0] opnd_q, opnd_d;
    logic [31:0]              acc_q, acc_d;
    logic                     zero_q, zero_d;
    logic                     done_q, done_d;
    logic [7:0]               count_q, count_d;
    logic [3:0]               op_code;
    logic                     start_edge;

    // start passes through three flops; a rise is seen once s2 is set and s3 still clear
    always_comb begin
        sync_d     = {sync_q[1:0], start};
        start_edge = sync_q[1] & ~sync_q[2];
    end

    // sequencing: latch the command, hold the ALU inputs for the settle time, then capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        count_d = count_q;
        if (clr) begin
            state_d = IDLE;
            acc_d   = 32'd0;
            zero_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (start_edge) begin
                    state_d = ISSUE;
                    op_d    = op_sel;
                    opnd_d  = operand_in;
                    cnt_d   = SETTLE_LOAD;
                end
                ISSUE: begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q == 4'd0) ? CAPTURE : ISSUE;
                end
                CAPTURE: begin
                    acc_d   = alu_result;
                    zero_d  = alu_zero;
                    count_d = count_q + 8'd1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // translate the board operation select into the ALU's control encoding
    always_comb begin
        op_code = 4'b0010;
        case (op_q)
            3'd0: op_code = 4'b0010;
            3'd1: op_code = 4'b0110;
            3'd2: op_code = 4'b0000;
            3'd3: op_code = 4'b0001;
            3'd4: op_code = 4'b1101;
            3'd5: op_code = 4'b0111;
            3'd6: op_code = 4'b1001;
            3'd7: op_code = 4'b1010;
            default: op_code = 4'b0010;
        endcase
    end

    // register update; reset dominates clr and everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 3'd0;
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            opnd_q  <= '0;
            acc_q   <= 32'd0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    // idle drives accumulator+0 so the ALU output is always meaningful
    assign alu_op1     = acc_q;
    assign alu_op2     = (state_q == IDLE) ? 32'd0 : 32'($signed(opnd_q));
    assign alu_op      = (state_q == IDLE) ? 4'b0010 : op_code;
    assign accumulator = acc_q;
    assign acc_zero    = zero_q;
    assign busy        = state_q != IDLE;
    assign done        = done_q;
    assign op_count    = count_q;
endmodule

// File: doc/alu_calc_ctrl.md
Name: alu_calc_ctrl

Overview:
- Initiator side of the ALU interface. Drives op1/op2/alu_op into the lab ALU and captures result/zero into a 32-bit accumulator.
- Operations are commanded by a push-button start, a 3-bit operation select and a 16-bit switch operand.
- Sits between board I/O (buttons, switches, LEDs) and the combinational ALU in the calculator top level.

Parameters:
- OPERAND_WIDTH, 16: width of operand_in; sign-extended to 32 bits for alu_op2.
- SETTLE_CYCLES, 1: cycles (1..15) ALU inputs are held stable before the result is captured.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  asynchronous push button; each rising edge requests one operation
- clr  in  1  synchronous clear; aborts any operation and zeroes the accumulator
- op_sel  in  3  operation select
- operand_in  in  OPERAND_WIDTH  signed operand from switches
- alu_op1  out  32  to ALU op1; always equals the accumulator
- alu_op2  out  32  to ALU op2
- alu_op  out  4  to ALU alu_op
- alu_result  in  32  from ALU result
- alu_zero  in  1  from ALU zero
- accumulator  out  32  current accumulator value
- acc_zero  out  1  registered ALU zero flag from the last capture
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse after each capture
- op_count  out  8  completed-operation counter

Behaviour:
- Reset (rst=1 at a clk edge):
  - accumulator=0, acc_zero=1, op_count=0, done=0, busy=0, state=IDLE.
  - Latched op and operand = 0; all three start synchroniser flops = 0.
- start synchroniser:
  - Three flops s1→s2→s3; edge = s2 & ~s3.
  - start is never used unsynchronised.
- op_sel mapping to alu_op:
  - 000 ADD 0010
  - 001 SUB 0110
  - 010 AND 0000
  - 011 OR 0001
  - 100 XOR 1101
  - 101 LT 0111
  - 110 SLL 1001
  - 111 SRA 1010
- ALU drive:
  - In IDLE: alu_op2=0 and alu_op=0010 (ADD), so the ALU shows accumulator+0.
  - In ISSUE and CAPTURE: alu_op2 = sign-extended latched operand, alu_op = mapped latched op_sel.
  - Values are stable for the whole operation.
- State machine: IDLE → ISSUE → CAPTURE → IDLE.
  - IDLE: when edge=1, latch op_sel and operand_in in that cycle, load settle counter with SETTLE_CYCLES-1, go to ISSUE.
  - ISSUE: decrement the counter; when the counter is 0, go to CAPTURE. ISSUE lasts exactly SETTLE_CYCLES cycles.
  - CAPTURE: accumulator<=alu_result, acc_zero<=alu_zero, op_count<=op_count+1 (modulo 256, 255→0), done<=1 for the next cycle, go to IDLE.
- Timing with SETTLE_CYCLES=1, start rising before clk edge k:
  - ISSUE entered at edge k+2.
  - CAPTURE entered at edge k+3.
  - accumulator and done update at edge k+4.
  - busy=1 from edge k+2 until edge k+4.
- Edges while busy are dropped, not queued. Holding start high yields exactly one operation.
- clr behaviour:
  - clr=1 at an edge in any state: accumulator=0, acc_zero=1, state=IDLE, done=0. op_count is unchanged.
  - clr and a capture at the same edge: clr wins; no count increment, no done pulse.
- rst asserted mid-operation behaves like the reset above and overrides clr.
- No arithmetic is done in this block; overflow and shifts are the ALU's. SLL/SRA amount = operand_in[4:0].

Test Plan:
- Reset, then ADD operand 5 twice → accumulator=0x0000000A, acc_zero=0, op_count=2, two done pulses each 1 cycle wide, at edge k+4 after each start rise.
- From 10: SUB 10 → accumulator=0, acc_zero=1. Then ADD operand 0xFFFF → accumulator=0xFFFFFFFF (sign extension).
- accumulator=0x80000000, SRA operand 4 → 0xF8000000; then SLL operand 4 → 0x80000000; then LT operand 0 → 1.
- Hold start high 50 cycles, and pulse start again while busy → exactly one operation, op_count increments by 1.
- Assert clr during ISSUE → accumulator=0, acc_zero=1, busy=0 next cycle, no done pulse, op_count unchanged.
- Issue 256 operations → op_count wraps to 0. Check that alu_op2 and alu_op never change while busy=1.
